// File: rtl/signal_field_gen.sv
// Builds the 802.11a SIGNAL field from RATE/LENGTH and serialises it LSB-first,
// one bit per accepted beat, for the convolutional-encoder chain.
module signal_field_gen #(
    parameter int TAIL_BITS = 6,
    parameter int CNT_W     = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                rate,
    input  logic [11:0]               length,
    input  logic                      out_ready,
    output logic                      bit_out,
    output logic                      bit_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [18+TAIL_BITS-1:0]   field_reg
);

    localparam int FIELD_W = 18 + TAIL_BITS;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FIELD_W - 1);

    if ((2 ** CNT_W) <= FIELD_W) begin : g_cnt_w_check
        $error("CNT_W is too narrow to index the whole field");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // RATE, reserved zero, LENGTH, even parity over bits 16:0, then zero tail.
    function automatic logic [FIELD_W-1:0] build_field(input logic [3:0]  r,
                                                       input logic [11:0] l);
        logic [16:0]        head;
        logic [FIELD_W-1:0] f;
        head     = {l, 1'b0, r};
        f        = '0;
        f[16:0]  = head;
        f[17]    = ^head;
        return f;
    endfunction

    state_t             state_q;
    logic [CNT_W-1:0]   idx_q;
    logic [FIELD_W-1:0] field_q;
    logic               bit_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [FIELD_W-1:0] field_d;
    logic               start_ok;
    logic               beat;

    assign field_d  = build_field(rate, length);
    assign start_ok = rate[3] && (length != 12'd0);
    assign beat     = bit_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            field_q     <= '0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            field_q     <= field_d;
                            idx_q       <= '0;
                            state_q     <= SEND;
                            bit_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q       <= '0;
                            state_q     <= DONE;
                            bit_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    bit_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Bit is driven from the registered index so a stalled beat holds its value.
    assign bit_out   = bit_valid_q & field_q[idx_q];
    assign bit_valid = bit_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign field_reg = field_q;

endmodule

// File: tb/tb_signal_field_gen.sv
// Table-driven bench for signal_field_gen with a serial-bit scoreboard queue.
module tb_signal_field_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  rate;
    logic [11:0] length;
    logic        out_ready;
    logic        bit_out;
    logic        bit_valid;
    logic        busy;
    logic        done;
    logic        err;
    logic [23:0] field_reg;

    int checks   = 0;
    int failures = 0;
    bit exp_q[$];

    signal_field_gen #(.TAIL_BITS(6), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rate      (rate),
        .length    (length),
        .out_ready (out_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .field_reg (field_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rate;
        logic [11:0] length;
        logic [23:0] exp_field;
        logic        exp_err;
        logic        toggle;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every valid cycle must show the head bit; a beat retires it.
    always @(negedge clk) begin
        if (rst && bit_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL bit_unexpected: bit_out=%0b with no expected bit", bit_out);
            end else begin
                if (bit_out !== exp_q[0]) begin
                    failures++;
                    $display("FAIL bit_out: got %0b expected %0b (remaining %0d)",
                             bit_out, exp_q[0], exp_q.size());
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (done || err) begin
            checks++;
            if (done && err) begin
                failures++;
                $display("FAIL done_err_excl: done=%0b err=%0b required not both", done, err);
            end
        end
    end

    initial begin
        logic [23:0] last_field;
        int n;

        vecs[0] = '{4'b1011, 12'h064, 24'h000C8B, 1'b0, 1'b0};
        vecs[1] = '{4'b1111, 12'hFFF, 24'h01FFEF, 1'b0, 1'b1};
        vecs[2] = '{4'b0011, 12'h064, 24'h000000, 1'b1, 1'b0};
        vecs[3] = '{4'b1011, 12'h000, 24'h000000, 1'b1, 1'b0};
        vecs[4] = '{4'b1101, 12'h5A3, 24'h02B46D, 1'b0, 1'b0};

        rst = 1'b0; start = 1'b0; rate = '0; length = '0; out_ready = 1'b1;
        last_field = '0;
        step();
        step();
        check("rst_bit_valid", 32'(bit_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_field", 32'(field_reg), 0);
        rst = 1'b1;
        step();
        check("idle_outputs", {26'd0, bit_out, bit_valid, busy, done, err, 1'b0}, 0);

        for (int v = 0; v < 5; v++) begin
            rate = vecs[v].rate;
            length = vecs[v].length;
            out_ready = 1'b1;
            start = 1'b1;
            if (!vecs[v].exp_err)
                for (int i = 0; i < 24; i++) exp_q.push_back(vecs[v].exp_field[i]);
            step();
            start = 1'b0;
            if (vecs[v].exp_err) begin
                check($sformatf("v%0d_err", v), 32'(err), 1);
                check($sformatf("v%0d_err_busy", v), 32'(busy), 0);
                check($sformatf("v%0d_err_valid", v), 32'(bit_valid), 0);
                check($sformatf("v%0d_err_field", v), 32'(field_reg), 32'(last_field));
                step();
                check($sformatf("v%0d_err_pulse", v), 32'(err), 0);
                check($sformatf("v%0d_err_valid2", v), 32'(bit_valid), 0);
            end else begin
                last_field = vecs[v].exp_field;
                check($sformatf("v%0d_field", v), 32'(field_reg), 32'(vecs[v].exp_field));
                check($sformatf("v%0d_busy", v), 32'(busy), 1);
                check($sformatf("v%0d_first_valid", v), 32'(bit_valid), 1);
                n = 1;
                while (!done && n < 200) begin
                    step();
                    n++;
                    if (vecs[v].toggle) out_ready = ~out_ready;
                end
                check($sformatf("v%0d_done_cycle", v), 32'(n), vecs[v].toggle ? 48 : 25);
                check($sformatf("v%0d_done_busy", v), 32'(busy), 0);
                check($sformatf("v%0d_done_valid", v), 32'(bit_valid), 0);
                check($sformatf("v%0d_bits_left", v), 32'(exp_q.size()), 0);
                out_ready = 1'b1;
                step();
                check($sformatf("v%0d_done_pulse", v), 32'(done), 0);
            end
        end

        // Reset in the middle of a field: no done, everything cleared.
        rate = 4'b1011; length = 12'h064; start = 1'b1;
        for (int i = 0; i < 24; i++) exp_q.push_back(vecs[0].exp_field[i]);
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_q.delete();
        check("midrst_valid", 32'(bit_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_field", 32'(field_reg), 0);
        for (int i = 0; i < 3; i++) begin
            check("midrst_no_done", 32'(done), 0);
            step();
        end
        check("midrst_idle_valid", 32'(bit_valid), 0);

        // start held high: two back-to-back fields, input changes during SEND ignored.
        rate = 4'b1011; length = 12'h001; start = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 24; i++) exp_q.push_back(1'(24'h00002B >> i));
        step();
        check("b2b_field1", 32'(field_reg), 32'h00002B);
        n = 1;
        while (!done && n < 200) begin
            step();
            n++;
            if (n == 3) begin rate = 4'b0111; length = 12'h7FF; end
            if (n == 6) begin rate = 4'b1011; length = 12'h001; end
        end
        check("b2b_done1_cycle", 32'(n), 25);
        step();
        check("b2b_gap_valid", 32'(bit_valid), 0);
        check("b2b_gap_busy", 32'(busy), 0);
        step();
        check("b2b_second_valid", 32'(bit_valid), 1);
        check("b2b_second_busy", 32'(busy), 1);
        check("b2b_field2", 32'(field_reg), 32'h00002B);
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            step();
            n++;
        end
        check("b2b_done2_cycle", 32'(n), 25);
        step();
        step();
        check("b2b_no_third", 32'(bit_valid), 0);
        check("b2b_bits_left", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signal_field_gen.md
Name: signal_field_gen

Overview:
- Builds the 24-bit 802.11a SIGNAL field from RATE and LENGTH.
- Fields: RATE, reserved, LENGTH, even parity, 6-bit tail.
- Serialises the field one bit per accepted beat, LSB-first, into the downstream convolutional-encoder/interleaver chain.
- Sits directly upstream of the 12-step symbol-position counter stage; `busy` gates that stage's run input.

Parameters:
- TAIL_BITS, 6, number of zero tail bits appended after parity; field length = 18 + TAIL_BITS.
- CNT_W, 5, width of the internal bit-index counter; must satisfy 2^CNT_W > 18 + TAIL_BITS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- start  input  1  request to build and send a field; sampled only in IDLE
- rate  input  4  RATE bits; rate[0] = R1 (sent first) ... rate[3] = R4
- length  input  12  PSDU length in octets; length[0] sent first
- out_ready  input  1  downstream can accept a bit this cycle
- bit_out  output  1  current serial bit
- bit_valid  output  1  bit_out is valid
- busy  output  1  high from accepted start until the last bit is accepted
- done  output  1  one-cycle pulse after the final bit is accepted
- err  output  1  one-cycle pulse when start is rejected
- field_reg  output  24  latched field image, for debug/verification

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, bit index=0, field_reg=0, bit_out=0, bit_valid=0, busy=0, done=0, err=0.
  - Reset overrides everything, including mid-transmission; no partial completion and no done pulse.
- Field layout, held in sig[23:0] (sig[0] sent first):
  - sig[3:0] = rate
  - sig[4] = 0 (reserved)
  - sig[16:5] = length
  - sig[17] = XOR of sig[16:0] (even parity)
  - sig[23:18] = 0 (tail)
- Validity check on start in IDLE:
  - Valid: rate[3]==1 and length!=0.
  - Invalid: err=1 for exactly the next cycle; stay IDLE; field_reg unchanged; busy stays 0.
- States:
  - IDLE: bit_valid=0. Valid start → latch field into field_reg, index=0, go to SEND. busy rises the cycle after start.
  - SEND: bit_valid=1, bit_out=field_reg[index] (combinational from registered index).
    - Beat occurs when bit_valid && out_ready.
    - Beat with index<23 → index+1.
    - Beat with index==23 → index=0, go to DONE.
    - out_ready=0 → hold index and bit_out; no timeout.
  - DONE: done=1, busy=0, bit_valid=0 for one cycle; then IDLE unconditionally.
- Latency:
  - First bit valid 1 cycle after an accepted start.
  - With out_ready held high, done asserts 25 cycles after start.
- Input sampling:
  - start, rate and length are sampled only in IDLE.
  - Changes during SEND/DONE are ignored.
  - start held high through DONE is re-sampled in IDLE; back-to-back fields are allowed, with gap = DONE + IDLE = 2 cycles.
- Output exclusivity: done and err never assert in the same cycle.

Test Plan:
1. rst=0 for 2 cycles, then rst=1 → all outputs 0, state IDLE.
2. start, rate=4'b1011, length=12'h064, out_ready=1:
   - field_reg=24'h000C8B.
   - Serial sequence: 1,1,0,1,0, 0,0,1,0,0,1,1,0,0,0,0,0, 0, then six 0s.
   - done pulses 25 cycles after start.
3. rate=4'b1111, length=12'hFFF:
   - parity=0 (16 ones); field_reg=24'h01FFEF.
   - out_ready toggled 1/0 each cycle → 24 beats over 47 cycles; bit_out stable while out_ready=0.
4. rate=4'b0011 (R4=0), then rate=4'b1011 with length=0 → err one-cycle pulse each time; bit_valid stays 0; busy stays 0.
5. rst=0 at bit index 10 of a field → next cycle: IDLE, bit_valid=0, busy=0, no done pulse.
6. start held high with length=12'h001 → two back-to-back fields (each field_reg=24'h00002B), done-to-next-first-bit gap of 2 cycles; start pulses during SEND are ignored.
